frame_capture_writer: RTL and testbench
=======================================

// Module: frame_capture_writer
// PURPOSE
// Camera-side writer for the 320x240 RGB444 frame buffer RAM that the VGA scan-out reads.
// Samples an OV7670-style camera bus (pclk/vsync/href/8-bit data) in the sys_clk domain.
// Pairs bytes into 12-bit RRRR_GGGG_BBBB pixels and generates raster-ordered write addresses.
// Raises ready_display once a full frame is stored.
// PARAMETERS
// H_ACTIVE  320  pixels stored per line
// V_ACTIVE  240  lines stored per frame
// ADDR_W    17   RAM address width; H_ACTIVE*V_ACTIVE must fit
// PIX_W     12   pixel width, RGB444
// PORTS
// sys_clk            in   1       100 MHz system clock; the only clock
// reset              in   1       asynchronous, active-high
// cam_pclk           in   1       camera pixel clock, async; sampled as data, <= sys_clk/4
// cam_vsync          in   1       camera vsync, async; high = vertical blanking
// cam_href           in   1       camera line valid, async
// cam_data           in   8       camera byte bus, async
// capture_en         in   1       level; allow capture of frames
// ram_write_address  out  ADDR_W  write address into buffer RAM
// ram_write_data     out  PIX_W   {R[3:0],G[3:0],B[3:0]}
// ram_write_enable   out  1       one-cycle write strobe per pixel
// ready_display      out  1       sticky; at least one complete frame stored
// frame_done         out  1       one-cycle pulse at end of each stored frame
// sync_error         out  1       sticky; odd byte count in a line or line overrun
// BEHAVIOUR
// - Reset: all outputs 0, FSM=IDLE, counters 0, byte phase 0. Reset mid-frame aborts it; no partial-frame flag.
// - Input path: cam_pclk/vsync/href/data each pass a 2-flop synchronizer.
//   pclk_rise = synced pclk 0->1. vsync/href/data are sampled on the same cycle, so delays are matched.
// - FSM:
//   IDLE  -> WAIT  when capture_en=1.
//   WAIT  -> CAPT  on synced vsync 1->0 (frame start); line_base=0, col=0, line=0, phase=0.
//   CAPT  -> DONE  when line==V_ACTIVE, or on vsync 0->1. An early vsync ends the frame as if complete.
//   DONE  -> WAIT  if capture_en=1, else IDLE. DONE lasts exactly one cycle.
// - Capture while in CAPT:
//   On pclk_rise with href=1, bytes alternate. Phase 0 latches byte[3:0] as R. Phase 1 forms the pixel {R, byte}.
//   A pixel is written only if col<H_ACTIVE and line<V_ACTIVE. Then col++.
//   Pixels with col>=H_ACTIVE are dropped and set sync_error.
// - Write timing:
//   ram_write_enable pulses 1 cycle, on the cycle after the phase-1 pclk_rise is detected.
//   Address and data are valid in that same cycle and held until the next write.
//   Address = line_base + col; no multiplier. Max address = H_ACTIVE*V_ACTIVE-1.
// - End of line (synced href 1->0):
//   If phase==1, the half pixel is discarded and sync_error set.
//   line_base += H_ACTIVE, line++, col=0, phase=0. Short lines leave their tail unwritten.
// - End of frame (DONE): frame_done=1 for that cycle; ready_display set; never cleared except by reset.
// - capture_en=0 during CAPT: the current frame completes, then IDLE. capture_en is not re-checked mid-frame.
// - href or pclk activity outside CAPT: ignored, no writes.
// - Latency: cam_pclk rise of the 2nd byte at the pins -> ram_write_enable within 3-4 sys_clk.
// STRUCTURE
// - Shared package frame_buffer_pkg: H_ACTIVE, V_ACTIVE, ADDR_W, PIX_W, FRAME_PIXELS, FSM state encoding.
//   The same constants are used by the VGA scan-out.
// - Sub-module cam_input_sync: 2-flop synchronizers plus pclk/href/vsync edge detect. Outputs are pulses and synced data.
// - Top level: FSM, byte pairing, col/line/line_base counters, output registers.
// TESTING
// 1. Reset, capture_en=1, one 320x240 frame of ramp bytes (pclk=sys_clk/4).
//    -> 76800 writes, addresses 0..76799 in order; pixel n data = {0x?A, 0xBC} -> 12'hABC.
//    -> frame_done 1 pulse; ready_display=1; sync_error=0.
// 2. A line with 330 pixels -> only 320 written for that line; next line starts at line_base+320; sync_error=1.
// 3. A line with 100 pixels then normal lines -> that line writes addresses base..base+99; next line starts at base+320.
// 4. A line with an odd byte count (641 bytes) -> 320 writes, last byte dropped; sync_error=1; next line phase=0.
// 5. Assert reset at line 100 of a frame -> outputs 0 within 1 cycle; the next vsync 1->0 restarts at address 0.
// 6. capture_en=0 at line 50 -> the frame completes (frame_done at line 240), then IDLE.
//    A second frame produces no writes.

Source files
------------

// File: rtl/frame_capture_writer_pkg.sv
// Constants and types shared by the camera-side frame writer and the VGA scan-out.
// Both sides address the same 320x240 RGB444 buffer.
package frame_buffer_pkg;

   localparam int H_ACTIVE     = 320;
   localparam int V_ACTIVE     = 240;
   localparam int ADDR_W       = 17;
   localparam int PIX_W        = 12;
   localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_CAPT = 2'd2,
      ST_DONE = 2'd3
   } cap_state_t;

   // The camera sends R in the low nibble of the first byte and {G,B} in the second byte.
   function automatic logic [PIX_W-1:0] pack_rgb444(input logic [3:0] red, input logic [7:0] gb);
      return {red, gb};
   endfunction

endpackage

// File: rtl/frame_capture_writer_if.sv
// Camera bus plus buffer-RAM write port of the frame capture writer.
// The slave side is the writer; the master side drives the camera pins and watches the RAM port.
interface frame_capture_writer_if;

   logic                                cam_pclk;
   logic                                cam_vsync;
   logic                                cam_href;
   logic [7:0]                          cam_data;
   logic [frame_buffer_pkg::ADDR_W-1:0] ram_write_address;
   logic [frame_buffer_pkg::PIX_W-1:0]  ram_write_data;
   logic                                ram_write_enable;

   modport master (
      output cam_pclk, cam_vsync, cam_href, cam_data,
      input  ram_write_address, ram_write_data, ram_write_enable
   );

   modport slave (
      input  cam_pclk, cam_vsync, cam_href, cam_data,
      output ram_write_address, ram_write_data, ram_write_enable
   );

endinterface

// File: rtl/frame_capture_writer_cam_input_sync.sv
// Brings the asynchronous camera bus into sys_clk with 2-flop synchronizers and detects edges.
// Every bit goes through the same flop depth so data stays aligned with the pclk edge.
module cam_input_sync (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_pclk,
   input  logic       i_vsync,
   input  logic       i_href,
   input  logic [7:0] i_data,
   output logic       o_pclk_rise,
   output logic       o_href,
   output logic       o_href_fall,
   output logic       o_vsync_rise,
   output logic       o_vsync_fall,
   output logic [7:0] o_data
);

   // Bit layout: [7:0] data, [8] pclk, [9] href, [10] vsync
   logic [10:0] r_meta;
   logic [10:0] r_sync;
   logic [2:0]  r_prev;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= 11'd0;
         r_sync <= 11'd0;
         r_prev <= 3'd0;
      end else begin
         r_meta <= {i_vsync, i_href, i_pclk, i_data};
         r_sync <= r_meta;
         r_prev <= r_sync[10:8];
      end
   end

   assign o_pclk_rise  =  r_sync[8]  & ~r_prev[0];
   assign o_href       =  r_sync[9];
   assign o_href_fall  = ~r_sync[9]  &  r_prev[1];
   assign o_vsync_rise =  r_sync[10] & ~r_prev[2];
   assign o_vsync_fall = ~r_sync[10] &  r_prev[2];
   assign o_data       =  r_sync[7:0];

endmodule

// File: rtl/frame_capture_writer.sv
// Camera-side writer for the RGB444 frame buffer: pairs camera bytes into pixels and
// writes them in raster order, flagging a stored frame and any line framing errors.
module frame_capture_writer
   import frame_buffer_pkg::*;
#(
   parameter int P_H_ACTIVE = H_ACTIVE,
   parameter int P_V_ACTIVE = V_ACTIVE
) (
   input  logic                   i_sys_clk,
   input  logic                   i_reset,
   input  logic                   i_capture_en,
   frame_capture_writer_if.slave  cam_ram,
   output logic                   o_ready_display,
   output logic                   o_frame_done,
   output logic                   o_sync_error
);

   localparam int COL_W  = $clog2(P_H_ACTIVE + 1);
   localparam int LINE_W = $clog2(P_V_ACTIVE + 1);

   logic       w_pclk_rise;
   logic       w_href;
   logic       w_href_fall;
   logic       w_vsync_rise;
   logic       w_vsync_fall;
   logic [7:0] w_data;

   cam_input_sync u_sync (
      .i_clk        (i_sys_clk),
      .i_rst        (i_reset),
      .i_pclk       (cam_ram.cam_pclk),
      .i_vsync      (cam_ram.cam_vsync),
      .i_href       (cam_ram.cam_href),
      .i_data       (cam_ram.cam_data),
      .o_pclk_rise  (w_pclk_rise),
      .o_href       (w_href),
      .o_href_fall  (w_href_fall),
      .o_vsync_rise (w_vsync_rise),
      .o_vsync_fall (w_vsync_fall),
      .o_data       (w_data)
   );

   cap_state_t        r_state;
   logic [COL_W-1:0]  r_col;
   logic [LINE_W-1:0] r_line;
   logic [ADDR_W-1:0] r_line_base;
   logic              r_phase;
   logic [3:0]        r_red;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [PIX_W-1:0]  r_wr_data;
   logic              r_wr_en;
   logic              r_frame_done;
   logic              r_ready;
   logic              r_sync_err;

   always_ff @(posedge i_sys_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_col        <= '0;
         r_line       <= '0;
         r_line_base  <= '0;
         r_phase      <= 1'b0;
         r_red        <= 4'h0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_wr_en      <= 1'b0;
         r_frame_done <= 1'b0;
         r_ready      <= 1'b0;
         r_sync_err   <= 1'b0;
      end else begin
         r_wr_en      <= 1'b0;
         r_frame_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_capture_en) r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (w_vsync_fall) begin
                  r_state     <= ST_CAPT;
                  r_col       <= '0;
                  r_line      <= '0;
                  r_line_base <= '0;
                  r_phase     <= 1'b0;
               end
            end
            ST_CAPT: begin
               // An early vsync closes the frame exactly like a full one.
               if (r_line == LINE_W'(P_V_ACTIVE) || w_vsync_rise) begin
                  r_state      <= ST_DONE;
                  r_frame_done <= 1'b1;
                  r_ready      <= 1'b1;
               end else if (w_href_fall) begin
                  if (r_phase) r_sync_err <= 1'b1;
                  r_line_base <= r_line_base + ADDR_W'(P_H_ACTIVE);
                  r_line      <= r_line + LINE_W'(1);
                  r_col       <= '0;
                  r_phase     <= 1'b0;
               end else if (w_pclk_rise && w_href) begin
                  if (!r_phase) begin
                     r_red   <= w_data[3:0];
                     r_phase <= 1'b1;
                  end else begin
                     r_phase <= 1'b0;
                     if (r_col < COL_W'(P_H_ACTIVE) && r_line < LINE_W'(P_V_ACTIVE)) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_line_base + ADDR_W'(r_col);
                        r_wr_data <= pack_rgb444(r_red, w_data);
                        r_col     <= r_col + COL_W'(1);
                     end else if (r_col >= COL_W'(P_H_ACTIVE)) begin
                        r_sync_err <= 1'b1;
                     end
                  end
               end
            end
            ST_DONE: begin
               r_state <= i_capture_en ? ST_WAIT : ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign cam_ram.ram_write_address = r_wr_addr;
   assign cam_ram.ram_write_data    = r_wr_data;
   assign cam_ram.ram_write_enable  = r_wr_en;
   assign o_ready_display           = r_ready;
   assign o_frame_done              = r_frame_done;
   assign o_sync_error              = r_sync_err;

endmodule

// File: tb/tb_frame_capture_writer.sv
// Directed bench for frame_capture_writer using a reduced 16x8 raster so whole frames stay short.
module tb_frame_capture_writer;
   import frame_buffer_pkg::*;

   localparam int H = 16;
   localparam int V = 8;

   logic sys_clk = 1'b0;
   logic rst;
   logic capture_en;
   logic ready_display;
   logic frame_done;
   logic sync_error;

   frame_capture_writer_if bus ();

   frame_capture_writer #(.P_H_ACTIVE(H), .P_V_ACTIVE(V)) dut (
      .i_sys_clk       (sys_clk),
      .i_reset         (rst),
      .i_capture_en    (capture_en),
      .cam_ram         (bus.slave),
      .o_ready_display (ready_display),
      .o_frame_done    (frame_done),
      .o_sync_error    (sync_error)
   );

   always #5 sys_clk = ~sys_clk;

   int n_assert = 0;
   int n_fail   = 0;

   logic [ADDR_W-1:0] obs_addr_q[$];
   logic [PIX_W-1:0]  obs_data_q[$];
   logic [ADDR_W-1:0] exp_addr_q[$];
   logic [PIX_W-1:0]  exp_data_q[$];
   int     fd_count = 0;
   int     hold_err = 0;
   int     lat_min  = 1000;
   int     lat_max  = 0;
   int     lat_now;
   longint t_rise   = 0;
   logic [ADDR_W+PIX_W-1:0] last_out = '0;

   // Record every RAM write, its latency from the 2nd-byte pclk rise, and frame_done pulses.
   always @(negedge sys_clk) begin
      if (bus.ram_write_enable) begin
         obs_addr_q.push_back(bus.ram_write_address);
         obs_data_q.push_back(bus.ram_write_data);
         lat_now = int'((longint'($time) - t_rise) / 10);
         if (lat_now < lat_min) lat_min = lat_now;
         if (lat_now > lat_max) lat_max = lat_now;
      end else if (!rst && {bus.ram_write_address, bus.ram_write_data} !== last_out) begin
         hold_err++;
      end
      last_out = {bus.ram_write_address, bus.ram_write_data};
      if (frame_done) fd_count++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   function automatic logic [11:0] pix(input int l, input int c);
      return 12'(12'hABC + 12'(l * 97) + 12'(c * 13));
   endfunction

   task automatic send_byte(input logic [7:0] b);
      bus.cam_data = b;
      bus.cam_pclk = 1'b0;
      wait_cyc(2);
      bus.cam_pclk = 1'b1;
      t_rise = longint'($time);
      wait_cyc(2);
   endtask

   // First byte carries R in its low nibble; the high nibble is junk that must be ignored.
   task automatic send_line(input int l, input int nb);
      logic [11:0] p;
      bus.cam_href = 1'b1;
      for (int i = 0; i < nb; i++) begin
         p = pix(l, i / 2);
         if (i % 2 == 0) send_byte({4'(i / 2) ^ 4'h5, p[11:8]});
         else            send_byte(p[7:0]);
      end
      bus.cam_pclk = 1'b0;
      bus.cam_href = 1'b0;
      wait_cyc(8);
   endtask

   task automatic expect_line(input int l, input int nb);
      if (l < V) begin
         for (int c = 0; c < nb / 2 && c < H; c++) begin
            exp_addr_q.push_back(ADDR_W'(l * H + c));
            exp_data_q.push_back(pix(l, c));
         end
      end
   endtask

   task automatic frame_start();
      bus.cam_vsync = 1'b1;
      wait_cyc(8);
      bus.cam_vsync = 1'b0;
      wait_cyc(8);
   endtask

   task automatic frame_end();
      bus.cam_vsync = 1'b1;
      wait_cyc(8);
   endtask

   task automatic run_frame(input int nlines, input int sp_line, input int sp_bytes,
                            input int off_line, input bit expect_wr);
      int nb;
      frame_start();
      for (int l = 0; l < nlines; l++) begin
         nb = (l == sp_line) ? sp_bytes : 2 * H;
         if (l == off_line) capture_en = 1'b0;
         send_line(l, nb);
         if (expect_wr) expect_line(l, nb);
      end
      frame_end();
   endtask

   task automatic check_writes(input string tag);
      int bad;
      bad = -1;
      chk({tag, " count"}, 64'(obs_addr_q.size()), 64'(exp_addr_q.size()));
      for (int i = 0; i < obs_addr_q.size() && i < exp_addr_q.size(); i++) begin
         if (bad < 0 && (obs_addr_q[i] !== exp_addr_q[i] || obs_data_q[i] !== exp_data_q[i])) bad = i;
      end
      n_assert++;
      assert (bad == -1) else begin
         n_fail++;
         $error("FAIL %s content: write %0d observed %0h/%0h expected %0h/%0h", tag, bad,
                obs_addr_q[bad], obs_data_q[bad], exp_addr_q[bad], exp_data_q[bad]);
      end
      obs_addr_q.delete();
      obs_data_q.delete();
      exp_addr_q.delete();
      exp_data_q.delete();
   endtask

   initial begin
      rst           = 1'b1;
      capture_en    = 1'b0;
      bus.cam_pclk  = 1'b0;
      bus.cam_vsync = 1'b0;
      bus.cam_href  = 1'b0;
      bus.cam_data  = 8'h00;
      wait_cyc(3);
      chk("reset outputs", 64'({bus.ram_write_enable, bus.ram_write_address, bus.ram_write_data,
                                ready_display, frame_done, sync_error}), 64'd0);
      rst = 1'b0;
      wait_cyc(2);

      // Full frame of well-formed lines.
      capture_en = 1'b1;
      wait_cyc(2);
      run_frame(V, -1, 0, -1, 1'b1);
      check_writes("full frame");
      chk("full frame_done pulses", 64'(fd_count), 64'd1);
      chk("full ready_display", 64'(ready_display), 64'd1);
      chk("full sync_error", 64'(sync_error), 64'd0);
      chk("write latency 3..4", 64'(lat_min >= 3 && lat_max <= 4), 64'd1);

      // Short line 2 (5 pixels): tail unwritten, no error.
      run_frame(V, 2, 10, -1, 1'b1);
      check_writes("short line");
      chk("short sync_error", 64'(sync_error), 64'd0);
      chk("short frame_done pulses", 64'(fd_count), 64'd2);

      // Long line 1 (21 pixels): only H stored, error raised.
      run_frame(V, 1, 2 * H + 10, -1, 1'b1);
      check_writes("long line");
      chk("long sync_error", 64'(sync_error), 64'd1);

      // Early vsync after 3 lines ends the frame.
      run_frame(3, -1, 0, -1, 1'b1);
      check_writes("early vsync");
      chk("early frame_done pulses", 64'(fd_count), 64'd4);

      // Reset in the middle of line 3.
      frame_start();
      for (int l = 0; l < 3; l++) send_line(l, 2 * H);
      bus.cam_href = 1'b1;
      for (int i = 0; i < 6; i++) send_byte(8'h5A);
      rst = 1'b1;
      #1;
      chk("mid-frame reset outputs", 64'({bus.ram_write_enable, bus.ram_write_address, bus.ram_write_data,
                                          ready_display, frame_done, sync_error}), 64'd0);
      wait_cyc(2);
      rst = 1'b0;
      obs_addr_q.delete();
      obs_data_q.delete();
      exp_addr_q.delete();
      exp_data_q.delete();
      bus.cam_pclk = 1'b0;
      bus.cam_href = 1'b0;
      wait_cyc(8);
      frame_end();

      // Odd byte count on line 3 of the next frame; capture restarts at address 0.
      run_frame(V, 3, 2 * H + 1, -1, 1'b1);
      check_writes("odd line after reset");
      chk("odd sync_error", 64'(sync_error), 64'd1);
      chk("odd frame_done pulses", 64'(fd_count), 64'd5);
      chk("odd ready_display", 64'(ready_display), 64'd1);

      // capture_en dropped mid-frame: frame completes, the next one is ignored.
      run_frame(V, -1, 0, 2, 1'b1);
      check_writes("capture_en off mid-frame");
      chk("off frame_done pulses", 64'(fd_count), 64'd6);
      run_frame(V, -1, 0, -1, 1'b0);
      check_writes("disabled frame");
      chk("disabled frame_done pulses", 64'(fd_count), 64'd6);

      chk("address/data held between writes", 64'(hold_err), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
